// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-port SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NPORT      = 3;
    localparam int unsigned CNT_W      = 4;

    localparam int unsigned VGA = 0;
    localparam int unsigned CAM = 1;
    localparam int unsigned FLT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/sram_arb_priority.sv
// Fixed-priority winner select (VGA > CAM > FLT) with a starvation override for FLT.
module sram_arb_priority
    import sram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic [NPORT-1:0] req,
    input  logic [CNT_W-1:0] wait_cnt,
    output logic [NPORT-1:0] win_c,
    output logic             flt_lose_c
);

    logic flt_starved_c;

    assign flt_starved_c = req[FLT] && (32'(wait_cnt) >= 32'(STARVE_LIMIT));

    always_comb begin
        win_c = '0;
        if (flt_starved_c) begin
            win_c[FLT] = 1'b1;
        end else if (req[VGA]) begin
            win_c[VGA] = 1'b1;
        end else if (req[CAM]) begin
            win_c[CAM] = 1'b1;
        end else if (req[FLT]) begin
            win_c[FLT] = 1'b1;
        end
    end

    assign flt_lose_c = req[FLT] && !win_c[FLT];

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter for an asynchronous 16-bit SRAM; each access is IDLE -> ADDR -> DATA.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [NPORT-1:0]  iReq,
    input  logic [NPORT-1:0]  iWe,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [ADDR_W-1:0] iAddr2,
    input  logic [DATA_W-1:0] iWdata0,
    input  logic [DATA_W-1:0] iWdata1,
    input  logic [DATA_W-1:0] iWdata2,
    output logic [NPORT-1:0]  oGnt,
    output logic [DATA_W-1:0] oRdata,
    output logic [NPORT-1:0]  oRvalid,
    output logic [ADDR_W-1:0] oSram_addr,
    inout  wire  [DATA_W-1:0] ioSram_dq,
    output logic              oSram_ce_n,
    output logic              oSram_oe_n,
    output logic              oSram_we_n,
    output logic              oSram_lb_n,
    output logic              oSram_ub_n
);

    state_t             state_q;
    logic [NPORT-1:0]   win_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic               dq_oe_q;

    logic [NPORT-1:0]   win_c;
    logic               flt_lose_c;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_we;
    logic [DATA_W-1:0]  sel_wdata;

    sram_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .req        (iReq),
        .wait_cnt   (wait_cnt_q),
        .win_c      (win_c),
        .flt_lose_c (flt_lose_c)
    );

    // Winner's request payload
    always_comb begin
        sel_addr  = iAddr0;
        sel_we    = iWe[VGA];
        sel_wdata = iWdata0;
        if (win_c[CAM]) begin
            sel_addr  = iAddr1;
            sel_we    = iWe[CAM];
            sel_wdata = iWdata1;
        end else if (win_c[FLT]) begin
            sel_addr  = iAddr2;
            sel_we    = iWe[FLT];
            sel_wdata = iWdata2;
        end
    end

    // FLT wait counter only moves on IDLE arbitrations; saturates rather than wrapping
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_IDLE) begin
            if (win_c[FLT]) begin
                wait_cnt_d = '0;
            end else if (flt_lose_c && (wait_cnt_q != {CNT_W{1'b1}})) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            dq_oe_q    <= 1'b0;
            oGnt       <= '0;
            oRvalid    <= '0;
            oRdata     <= '0;
            oSram_addr <= '0;
            oSram_ce_n <= 1'b1;
            oSram_oe_n <= 1'b1;
            oSram_we_n <= 1'b1;
        end else begin
            oGnt       <= '0;
            oRvalid    <= '0;
            wait_cnt_q <= wait_cnt_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (|iReq) begin
                        state_q    <= ST_ADDR;
                        win_q      <= win_c;
                        we_q       <= sel_we;
                        wdata_q    <= sel_wdata;
                        oSram_addr <= sel_addr;
                        oSram_ce_n <= 1'b0;
                        oSram_oe_n <= sel_we;
                    end
                end
                ST_ADDR: begin
                    state_q <= ST_DATA;
                    oGnt    <= win_q;
                    if (we_q) begin
                        oSram_we_n <= 1'b0;
                        dq_oe_q    <= 1'b1;
                    end
                end
                ST_DATA: begin
                    state_q    <= ST_IDLE;
                    oSram_ce_n <= 1'b1;
                    oSram_oe_n <= 1'b1;
                    oSram_we_n <= 1'b1;
                    dq_oe_q    <= 1'b0;
                    if (!we_q) begin
                        oRdata  <= ioSram_dq;
                        oRvalid <= win_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ioSram_dq  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign oSram_lb_n = 1'b0;
    assign oSram_ub_n = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reads, fixed priority, starvation override, write timing, reset abort.
module tb_sram_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [2:0]  iReq;
    logic [2:0]  iWe;
    logic [19:0] iAddr0, iAddr1, iAddr2;
    logic [15:0] iWdata0, iWdata1, iWdata2;
    logic [2:0]  oGnt;
    logic [15:0] oRdata;
    logic [2:0]  oRvalid;
    logic [19:0] oSram_addr;
    wire  [15:0] ioSram_dq;
    logic        oSram_ce_n, oSram_oe_n, oSram_we_n, oSram_lb_n, oSram_ub_n;

    int checks   = 0;
    int failures = 0;
    logic [2:0] eg;

    always #5 iClk = ~iClk;

    // Undriven bus reads back as all ones, so high-Z shows up as 16'hFFFF
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (ioSram_dq[i]);
    end

    function automatic logic [15:0] sram_model(input logic [19:0] a);
        if (a == 20'h00100) return 16'h0080;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    logic sram_drv;
    assign sram_drv  = !oSram_ce_n && !oSram_oe_n && oSram_we_n;
    assign ioSram_dq = sram_drv ? sram_model(oSram_addr) : 16'hzzzz;

    sram_arbiter #(
        .ADDR_W       (20),
        .STARVE_LIMIT (8)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iReq       (iReq),
        .iWe        (iWe),
        .iAddr0     (iAddr0),
        .iAddr1     (iAddr1),
        .iAddr2     (iAddr2),
        .iWdata0    (iWdata0),
        .iWdata1    (iWdata1),
        .iWdata2    (iWdata2),
        .oGnt       (oGnt),
        .oRdata     (oRdata),
        .oRvalid    (oRvalid),
        .oSram_addr (oSram_addr),
        .ioSram_dq  (ioSram_dq),
        .oSram_ce_n (oSram_ce_n),
        .oSram_oe_n (oSram_oe_n),
        .oSram_we_n (oSram_we_n),
        .oSram_lb_n (oSram_lb_n),
        .oSram_ub_n (oSram_ub_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRst = 1'b0; iReq = '0; iWe = '0;
        iAddr0 = '0; iAddr1 = '0; iAddr2 = '0;
        iWdata0 = '0; iWdata1 = '0; iWdata2 = '0;
        tick();
        tick();

        // Reset values
        chk("rst_gnt",   32'(oGnt), 32'h0);
        chk("rst_rv",    32'(oRvalid), 32'h0);
        chk("rst_rdata", 32'(oRdata), 32'h0);
        chk("rst_addr",  32'(oSram_addr), 32'h0);
        chk("rst_ce",    32'(oSram_ce_n), 32'h1);
        chk("rst_oe",    32'(oSram_oe_n), 32'h1);
        chk("rst_we",    32'(oSram_we_n), 32'h1);
        chk("rst_lbub",  32'({oSram_lb_n, oSram_ub_n}), 32'h0);
        chk("rst_dq",    32'(ioSram_dq), 32'hFFFF);
        iRst = 1'b1;
        tick();
        chk("idle_gnt", 32'(oGnt), 32'h0);
        chk("idle_ce",  32'(oSram_ce_n), 32'h1);

        // Single FLT read of 0x00100, SRAM returns 0x0080
        iReq = 3'b100; iAddr2 = 20'h00100;
        tick();
        chk("t1_addr_gnt", 32'(oGnt), 32'h0);
        chk("t1_addr",     32'(oSram_addr), 32'h00100);
        chk("t1_addr_ce",  32'(oSram_ce_n), 32'h0);
        chk("t1_addr_oe",  32'(oSram_oe_n), 32'h0);
        chk("t1_addr_we",  32'(oSram_we_n), 32'h1);
        tick();
        chk("t1_gnt",     32'(oGnt), 32'h4);
        chk("t1_data_oe", 32'(oSram_oe_n), 32'h0);
        iReq = 3'b000;
        tick();
        chk("t1_post_gnt", 32'(oGnt), 32'h0);
        chk("t1_rv",       32'(oRvalid), 32'h4);
        chk("t1_rdata",    32'(oRdata), 32'h0080);
        chk("t1_post_ce",  32'(oSram_ce_n), 32'h1);
        tick();
        chk("t1_rv_clr",    32'(oRvalid), 32'h0);
        chk("t1_rdata_hld", 32'(oRdata), 32'h0080);

        // Simultaneous requests from all three ports, top address on CAM
        iReq = 3'b111; iAddr0 = 20'h00010; iAddr1 = 20'hFFFFF; iAddr2 = 20'h00030;
        for (int c = 1; c <= 9; c++) begin
            tick();
            eg = (c == 2) ? 3'b001 : (c == 5) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
            chk($sformatf("t2_gnt_c%0d", c), 32'(oGnt), 32'(eg));
            iReq = iReq & ~eg;
            case (c)
                1: chk("t2_addr_p0", 32'(oSram_addr), 32'h00010);
                4: chk("t2_addr_p1", 32'(oSram_addr), 32'hFFFFF);
                7: chk("t2_addr_p2", 32'(oSram_addr), 32'h00030);
                3: begin
                    chk("t2_rv_p0", 32'(oRvalid), 32'h1);
                    chk("t2_rd_p0", 32'(oRdata), 32'h5A4A);
                end
                6: begin
                    chk("t2_rv_p1", 32'(oRvalid), 32'h2);
                    chk("t2_rd_p1", 32'(oRdata), 32'hA5A5);
                end
                9: begin
                    chk("t2_rv_p2", 32'(oRvalid), 32'h4);
                    chk("t2_rd_p2", 32'(oRdata), 32'h5A6A);
                end
                default: ;
            endcase
        end
        chk("t2_cnt", 32'(dut.wait_cnt_q), 32'h0);

        // VGA hogs the bus; FLT must win its 9th arbitration
        iReq = 3'b101;
        for (int c = 1; c <= 29; c++) begin
            tick();
            eg = ((c % 3) == 2) ? ((c == 26) ? 3'b100 : 3'b001) : 3'b000;
            chk($sformatf("t3_gnt_c%0d", c), 32'(oGnt), 32'(eg));
            if (c == 22) chk("t3_cnt_full", 32'(dut.wait_cnt_q), 32'h8);
            if (c == 25) chk("t3_cnt_clr",  32'(dut.wait_cnt_q), 32'h0);
            if (c == 27) chk("t3_rd_p2",    32'(oRdata), 32'h5A6A);
            if (c == 26) iReq[2] = 1'b0;
            if (c == 29) iReq = 3'b000;
        end
        tick();

        // CAM write of 0x1234 to 0x4B000
        iWe = 3'b010; iAddr1 = 20'h4B000; iWdata1 = 16'h1234; iReq = 3'b010;
        tick();
        chk("t4_addr",   32'(oSram_addr), 32'h4B000);
        chk("t4_a_ce",   32'(oSram_ce_n), 32'h0);
        chk("t4_a_oe",   32'(oSram_oe_n), 32'h1);
        chk("t4_a_we",   32'(oSram_we_n), 32'h1);
        chk("t4_a_dq",   32'(ioSram_dq), 32'hFFFF);
        chk("t4_a_gnt",  32'(oGnt), 32'h0);
        tick();
        chk("t4_d_gnt",  32'(oGnt), 32'h2);
        chk("t4_d_we",   32'(oSram_we_n), 32'h0);
        chk("t4_d_oe",   32'(oSram_oe_n), 32'h1);
        chk("t4_d_dq",   32'(ioSram_dq), 32'h1234);
        iReq = 3'b000;
        tick();
        chk("t4_i_we",    32'(oSram_we_n), 32'h1);
        chk("t4_i_dq",    32'(ioSram_dq), 32'hFFFF);
        chk("t4_i_gnt",   32'(oGnt), 32'h0);
        chk("t4_i_rv",    32'(oRvalid), 32'h0);
        chk("t4_i_ce",    32'(oSram_ce_n), 32'h1);
        chk("t4_rd_hold", 32'(oRdata), 32'h5A4A);

        // Reset dropped mid-DATA of a CAM write aborts it; CAM is re-granted after release
        iReq = 3'b010;
        tick();
        tick();
        chk("t5_in_data_we", 32'(oSram_we_n), 32'h0);
        iRst = 1'b0;
        #1;
        chk("t5_rst_gnt",   32'(oGnt), 32'h0);
        chk("t5_rst_we",    32'(oSram_we_n), 32'h1);
        chk("t5_rst_ce",    32'(oSram_ce_n), 32'h1);
        chk("t5_rst_oe",    32'(oSram_oe_n), 32'h1);
        chk("t5_rst_dq",    32'(ioSram_dq), 32'hFFFF);
        chk("t5_rst_rdata", 32'(oRdata), 32'h0);
        chk("t5_rst_addr",  32'(oSram_addr), 32'h0);
        chk("t5_rst_rv",    32'(oRvalid), 32'h0);
        tick();
        chk("t5_rst_edge_gnt", 32'(oGnt), 32'h0);
        iRst = 1'b1;
        tick();
        chk("t5_re_addr", 32'(oSram_addr), 32'h4B000);
        chk("t5_re_agnt", 32'(oGnt), 32'h0);
        tick();
        chk("t5_re_gnt",  32'(oGnt), 32'h2);
        chk("t5_re_dq",   32'(ioSram_dq), 32'h1234);
        iReq = 3'b000; iWe = 3'b000;
        tick();
        chk("t5_end_gnt", 32'(oGnt), 32'h0);
        chk("t5_end_dq",  32'(ioSram_dq), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
